// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared widths, FSM states and the FIFO entry
// type for the register-file writeback arbiter.
package regfile_writeback_arbiter_pkg;

  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_arbiter_fifo.sv
// Small synchronous FIFO buffering MDU results
// ({reg, data}) until the write port is free.
module wb_result_fifo
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // storage needs no reset; validity comes from count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Merges pipeline writeback and buffered MDU results
// onto the register-file write port; tracks MDU busy regs.
module regfile_writeback_arbiter
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_reg,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                mdu_valid,
  output logic                mdu_ready,
  input  logic [REG_W-1:0]    mdu_reg,
  input  logic [DATA_W-1:0]   mdu_data,
  input  logic                issue_valid,
  input  logic [REG_W-1:0]    issue_reg,
  output logic                we,
  output logic [REG_W-1:0]    writeRegister,
  output logic [DATA_W-1:0]   writeData,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                stall_req
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t           mdu_entry;
  wb_entry_t           head;
  logic                full;
  logic                empty;
  logic [AW:0]         count;
  logic                push;
  logic                pop;
  state_t              state;
  logic [CW-1:0]       starve_cnt;
  logic [NUM_REGS-1:0] busy_next;

  assign mdu_entry = '{rd: mdu_reg, data: mdu_data};
  assign mdu_ready = !full;
  assign push      = mdu_valid && mdu_ready;
  assign pop       = !wb_valid && !empty;
  assign stall_req = (state == DRAIN);

  wb_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (mdu_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // register the arbitration winner; r0 is consumed silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we            <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else begin
      unique case (1'b1)
        wb_valid: begin
          we            <= (wb_reg != '0);
          writeRegister <= wb_reg;
          writeData     <= wb_data;
        end
        pop: begin
          we            <= (head.rd != '0);
          writeRegister <= head.rd;
          writeData     <= head.data;
        end
        default: we <= 1'b0;
      endcase
    end
  end

  // retire clears first so a same-cycle issue wins
  always_comb begin
    busy_next = busy_mask;
    if (pop) busy_next[head.rd] = 1'b0;
    if (issue_valid && issue_reg != '0)
      busy_next[issue_reg] = 1'b1;
  end

  // busy scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_mask <= '0;
    else     busy_mask <= busy_next;
  end

  // starvation watchdog: force a drain after too many lost cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      case (state)
        NORMAL: begin
          if (starve_cnt == CW'(STARVE_LIMIT)) begin
            state      <= DRAIN;
            starve_cnt <= '0;
          end else if (pop || count == '0) begin
            starve_cnt <= '0;
          end else if (wb_valid) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (empty) state <= NORMAL;
        end
        default: state <= NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Scoreboard bench: stimulus pushes expected writes,
// a negedge monitor pops and compares each DUT write.
module tb_regfile_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        mdu_valid = 1'b0;
  logic        mdu_ready;
  logic [4:0]  mdu_reg = '0;
  logic [31:0] mdu_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_reg = '0;
  logic        we;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [31:0] busy_mask;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  logic [36:0] exp_q[$];
  logic [36:0] mq[$];

  regfile_writeback_arbiter #(
    .FIFO_DEPTH   (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .mdu_valid     (mdu_valid),
    .mdu_ready     (mdu_ready),
    .mdu_reg       (mdu_reg),
    .mdu_data      (mdu_data),
    .issue_valid   (issue_valid),
    .issue_reg     (issue_reg),
    .we            (we),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .busy_mask     (busy_mask),
    .stall_req     (stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual %h/%h required none",
                 writeRegister, writeData);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({writeRegister, writeData} !== e) begin
          errors++;
          $display("FAIL write actual %h/%h required %h/%h",
                   writeRegister, writeData, e[36:32], e[31:0]);
        end
      end
    end
  end

  // reference arbitration for the coming edge, then advance
  task automatic step();
    int sz;
    logic [36:0] e;
    sz = mq.size();
    if (wb_valid) begin
      if (wb_reg != 5'd0) exp_q.push_back({wb_reg, wb_data});
    end else if (sz > 0) begin
      e = mq.pop_front();
      if (e[36:32] != 5'd0) exp_q.push_back(e);
    end
    if (mdu_valid && sz < 4) mq.push_back({mdu_reg, mdu_data});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0;
    mdu_valid = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, {31'd0, we}, 32'd0);
    chk({tag, "_wreg"}, {27'd0, writeRegister}, 32'd0);
    chk({tag, "_wdata"}, writeData, 32'd0);
    chk({tag, "_busy"}, busy_mask, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall_req}, 32'd0);
    chk({tag, "_ready"}, {31'd0, mdu_ready}, 32'd1);
  endtask

  initial begin
    #3;
    chk_reset_vals("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // pipeline write
    wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEADBEEF;
    step();
    chk("wb_we", {31'd0, we}, 32'd1);
    chk("wb_reg", {27'd0, writeRegister}, 32'd5);
    chk("wb_data", writeData, 32'hDEADBEEF);
    idle();
    step();
    chk("wb_we_drop", {31'd0, we}, 32'd0);

    // issue then MDU result for reg 9
    issue_valid = 1'b1; issue_reg = 5'd9;
    step();
    chk("busy9_set", {31'd0, busy_mask[9]}, 32'd1);
    idle();
    mdu_valid = 1'b1; mdu_reg = 5'd9; mdu_data = 32'h1234;
    step();
    idle();
    chk("mdu_no_bypass", {31'd0, we}, 32'd0);
    chk("busy9_hold", {31'd0, busy_mask[9]}, 32'd1);
    step();
    chk("mdu_we", {31'd0, we}, 32'd1);
    chk("mdu_reg", {27'd0, writeRegister}, 32'd9);
    chk("busy9_clr", {31'd0, busy_mask[9]}, 32'd0);

    // register 0 from both sources
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'h55;
    step();
    chk("r0_wb_we", {31'd0, we}, 32'd0);
    idle();
    mdu_valid = 1'b1; mdu_reg = 5'd0; mdu_data = 32'h77;
    step();
    idle();
    step();
    chk("r0_mdu_we", {31'd0, we}, 32'd0);
    chk("r0_ready", {31'd0, mdu_ready}, 32'd1);
    step();

    // starvation: fill FIFO under continuous pipeline writes
    for (int k = 0; k < 10; k++) begin
      wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'h100 + k;
      mdu_valid = (k < 4);
      mdu_reg = 5'd10 + 5'(k); mdu_data = 32'hA0 + k;
      step();
      if (k == 3) chk("full_ready", {31'd0, mdu_ready}, 32'd0);
      if (k == 8) chk("stall_pre", {31'd0, stall_req}, 32'd0);
      if (k == 9) chk("stall_on", {31'd0, stall_req}, 32'd1);
    end
    idle();
    for (int j = 0; j < 4; j++) begin
      step();
      if (j == 0) chk("drain_ready", {31'd0, mdu_ready}, 32'd1);
      if (j == 3) chk("stall_hold", {31'd0, stall_req}, 32'd1);
    end
    step();
    chk("stall_off", {31'd0, stall_req}, 32'd0);

    // same-cycle issue and retire on reg 7
    issue_valid = 1'b1; issue_reg = 5'd7;
    step();
    idle();
    mdu_valid = 1'b1; mdu_reg = 5'd7; mdu_data = 32'h77;
    step();
    idle();
    issue_valid = 1'b1; issue_reg = 5'd7;
    step();
    idle();
    chk("set_wins_we", {31'd0, we}, 32'd1);
    chk("set_wins_busy7", {31'd0, busy_mask[7]}, 32'd1);

    // reset with entries queued and busy bits set
    issue_valid = 1'b1; issue_reg = 5'd3;
    step();
    issue_reg = 5'd4;
    step();
    issue_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'h200 + k;
      mdu_valid = 1'b1;
      mdu_reg = 5'd20 + 5'(k); mdu_data = 32'hB0 + k;
      step();
    end
    idle();
    chk("pre_rst_busy", busy_mask, 32'h0000_0098);
    #2;
    rst = 1'b1;
    exp_q.delete();
    mq.delete();
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_rst_we", {31'd0, we}, 32'd0);
    end
    chk("post_rst_busy", busy_mask, 32'd0);

    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_arbiter.md
# regfile_writeback_arbiter

Write-side front end for the 32×32 register file. It merges two result sources into the register file's single write port (we / writeRegister / writeData):
- the in-order main pipeline writeback, which cannot stall;
- a long-latency multiply/divide unit (MDU), which uses a valid/ready handshake and is buffered in a small FIFO.

It also keeps a per-register busy scoreboard for outstanding MDU destinations, which the hazard unit reads.

## Interface
Parameters:
- FIFO_DEPTH, 4: MDU result buffer entries (power of two, ≥2).
- STARVE_LIMIT, 8: consecutive lost arbitration cycles before a forced drain.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- wb_valid  in  1  main-pipeline result valid this cycle.
- wb_reg  in  5  main-pipeline destination.
- wb_data  in  32  main-pipeline result.
- mdu_valid  in  1  MDU result offered.
- mdu_ready  out  1  FIFO can accept; equals !full.
- mdu_reg  in  5  MDU destination.
- mdu_data  in  32  MDU result.
- issue_valid  in  1  long-latency op issued this cycle.
- issue_reg  in  5  its destination.
- we  out  1  register-file write enable.
- writeRegister  out  5  register-file write address.
- writeData  out  32  register-file write data.
- busy_mask  out  32  bit r=1 means an MDU result for r is outstanding.
- stall_req  out  1  request to the hazard unit to freeze wb_valid.

## Operation
- **Arbitration, once per cycle.**
  - wb_valid=1 wins the write port.
  - Otherwise, if the FIFO is non-empty, pop the head.
  - Otherwise, idle.
- **Register 0.** The winning entry is registered into writeRegister/writeData. we is 1 only if the destination is not 0. A write to r0 is consumed (popped or retired) with we=0.
- **MDU push.** A push occurs when mdu_valid && mdu_ready.
  - No same-cycle push-to-pop bypass: a pushed entry is eligible no earlier than the next cycle.
  - Push and pop may coincide when the FIFO is non-full.
- **Scoreboard.**
  - issue_valid sets busy[issue_reg]; busy[0] is never set.
  - When an MDU entry retires (popped by arbitration), busy[entry.reg] is cleared.
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - Issue to a register that is already busy is a hazard-unit contract violation; the bit simply stays set.
- **Starvation FSM, states NORMAL and DRAIN.**
  - NORMAL: starve_cnt increments each cycle the FIFO is non-empty and wb_valid=1. It clears on any pop or when the FIFO is empty.
  - When starve_cnt reaches STARVE_LIMIT, move to DRAIN.
  - DRAIN: stall_req=1. The pipeline contract is wb_valid=0 while stall_req=1; if wb_valid is asserted anyway, the pipeline still wins and nothing is dropped.
  - Leave DRAIN the cycle after the FIFO becomes empty; starve_cnt is 0 on return to NORMAL.
- **Data width.** Data passes through unmodified; there is no arithmetic on the data path.

## Timing
- **Reset values:**
  - we=0, writeRegister=0, writeData=0.
  - busy_mask=0, stall_req=0.
  - FIFO empty, so mdu_ready=1.
  - FSM=NORMAL, starve_cnt=0.
- **Reset mid-operation:** asynchronously discards FIFO contents and busy bits. In-flight MDU results are lost; the MDU is reset by the same rst.
- **Pipeline latency:** wb_valid at posedge N gives we/writeRegister/writeData valid from N+1 for exactly one cycle. The register file samples them on its negedge within that cycle.
- **MDU latency:** push at N gives the earliest write at N+2.
- **busy_mask:** registered. A set issued at N is visible at N+1. A clear from a pop at N is visible at N+1, aligned with we.
- **stall_req:** registered; asserted the cycle after starve_cnt reaches STARVE_LIMIT.
- **Back-pressure:** mdu_ready is derived from the current count only. When full, mdu_ready=0 even if a pop occurs that cycle.

## Structure
- The shared pipeline package holds REG_W=5, DATA_W=32, NUM_REGS=32 and the FSM state enum {NORMAL, DRAIN}.
- Sub-module wb_result_fifo: synchronous FIFO carrying {reg, data}, with push, pop, full, empty and count outputs. It uses the same clk/rst.
- Top level: arbiter, output register, scoreboard and starvation FSM.

## Test plan
- Reset, then wb_valid=1, wb_reg=5, wb_data=0xDEADBEEF for one cycle -> next cycle we=1, writeRegister=5, writeData=0xDEADBEEF; the cycle after that, we=0.
- issue_valid with reg 9, then MDU push {9, 0x1234} with wb_valid=0 -> busy_mask[9]=1 until the write; we=1, writeRegister=9 two cycles after the push; busy_mask[9]=0 in the same cycle.
- wb_valid=1 with reg 0 -> no write (we stays 0); MDU push to reg 0 -> popped with we=0 and the FIFO empties.
- Four MDU pushes while wb_valid=1 continuously -> mdu_ready=0 after the 4th; stall_req=1 after 8 lost cycles. With wb_valid=0 the 4 writes appear in order, then stall_req drops.
- Same-cycle issue_valid(reg 7) and retire of an MDU entry for reg 7 -> busy_mask[7] remains 1.
- Assert rst with 3 FIFO entries and busy bits set -> outputs return to reset values immediately (asynchronously); no writes follow.
